// File: rtl/c0_exc_ctrl_if.sv
// Commit-stage, interrupt and mtc0/mfc0 signal bundle between the pipeline
// (master) and the CP0 exception controller (slave).
interface c0_exc_ctrl_if #(
   parameter int NUM_HW_INT = 6
);
   logic [NUM_HW_INT-1:0] hw_int;
   logic                  pc_valid;
   logic [31:0]           pc_i;
   logic                  in_delay_slot;
   logic                  sync_exc;
   logic [4:0]            exc_code_i;
   logic                  eret;
   logic                  c0_we;
   logic [4:0]            c0_waddr;
   logic [31:0]           c0_wdata;
   logic [4:0]            c0_raddr;
   logic [31:0]           c0_rdata;
   logic                  flush;
   logic [31:0]           redirect_pc;
   logic                  int_pending;

   modport master (
      output hw_int, pc_valid, pc_i, in_delay_slot, sync_exc, exc_code_i, eret,
             c0_we, c0_waddr, c0_wdata, c0_raddr,
      input  c0_rdata, flush, redirect_pc, int_pending
   );

   modport slave (
      input  hw_int, pc_valid, pc_i, in_delay_slot, sync_exc, exc_code_i, eret,
             c0_we, c0_waddr, c0_wdata, c0_raddr,
      output c0_rdata, flush, redirect_pc, int_pending
   );
endinterface

// File: rtl/c0_exc_ctrl.sv
// CP0 exception/interrupt controller: owns Count, Compare, Status, Cause, EPC,
// arbitrates sync exceptions, interrupts and ERET at commit, and issues a
// one-cycle flush with redirect PC.
module c0_exc_ctrl #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
   parameter int          NUM_HW_INT   = 6
) (
   input  logic         sys_clk,
   input  logic         rst,
   c0_exc_ctrl_if.slave bus
);
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

   state_t                state_q, state_d;
   logic [31:0]           count_q, compare_q, epc_q, redirect_q;
   logic                  cnt_tog_q;
   logic [7:0]            im_q;
   logic                  exl_q, ie_q;
   logic                  bd_q, ti_q;
   logic [1:0]            ip_sw_q;
   logic [NUM_HW_INT-1:0] ip_hw_q;
   logic [4:0]            exc_code_q;

   logic [7:0]            cause_ip;
   logic                  int_pend;
   logic                  take_sync, take_int, take_eret, take_exc, take_any;
   logic                  wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic [31:0]           count_d;
   logic                  count_upd;
   logic [31:0]           rdata;

   // Assemble Cause.IP: software bits, mirrored hw lines, timer folded into IP7
   always_comb begin
      cause_ip                      = '0;
      cause_ip[1:0]                 = ip_sw_q;
      cause_ip[2+NUM_HW_INT-1:2]    = ip_hw_q;
      cause_ip[7]                   = cause_ip[7] | ti_q;
   end

   assign int_pend        = (|(cause_ip & im_q)) & ie_q & ~exl_q;
   assign bus.int_pending = int_pend;
   assign bus.flush       = (state_q != RUN);
   assign bus.redirect_pc = redirect_q;

   // Commit arbitration: sync exception > interrupt > eret, only while in RUN
   always_comb begin
      state_d   = RUN;
      take_sync = 1'b0;
      take_int  = 1'b0;
      take_eret = 1'b0;
      if (state_q == RUN && bus.pc_valid) begin
         if (bus.sync_exc) begin
            take_sync = 1'b1;
            state_d   = TRAP;
         end else if (int_pend) begin
            take_int = 1'b1;
            state_d  = TRAP;
         end else if (bus.eret) begin
            take_eret = 1'b1;
            state_d   = RET;
         end
      end
   end

   assign take_exc = take_sync | take_int;
   assign take_any = take_exc | take_eret;

   // Status/Cause/EPC writes lose to a same-cycle exception or ERET
   assign wr_count   = bus.c0_we && (bus.c0_waddr == REG_COUNT);
   assign wr_compare = bus.c0_we && (bus.c0_waddr == REG_COMPARE);
   assign wr_status  = bus.c0_we && (bus.c0_waddr == REG_STATUS) && !take_any;
   assign wr_cause   = bus.c0_we && (bus.c0_waddr == REG_CAUSE)  && !take_any;
   assign wr_epc     = bus.c0_we && (bus.c0_waddr == REG_EPC)    && !take_any;

   // Timer match is only evaluated when Count actually takes a new value, so
   // the idle Count==Compare==0 state after reset does not raise TI.
   assign count_d   = wr_count ? bus.c0_wdata : count_q + {31'b0, cnt_tog_q};
   assign count_upd = wr_count | cnt_tog_q;

   // FSM state register
   always_ff @(posedge sys_clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Half-rate Count, Compare and timer interrupt flag
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         count_q   <= '0;
         cnt_tog_q <= 1'b0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         cnt_tog_q <= wr_count ? 1'b0 : ~cnt_tog_q;
         if (wr_compare) begin
            compare_q <= bus.c0_wdata;
            ti_q      <= 1'b0;
         end else if (count_upd && (count_d == compare_q)) begin
            ti_q <= 1'b1;
         end
      end
   end

   // Status: exception entry/return own EXL, otherwise mtc0
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         im_q  <= '0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
      end else if (take_exc) begin
         exl_q <= 1'b1;
      end else if (take_eret) begin
         exl_q <= 1'b0;
      end else if (wr_status) begin
         im_q  <= bus.c0_wdata[15:8];
         exl_q <= bus.c0_wdata[1];
         ie_q  <= bus.c0_wdata[0];
      end
   end

   // Cause, EPC and redirect target; nested exceptions keep the original EPC/BD
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
         epc_q      <= '0;
         redirect_q <= '0;
      end else begin
         ip_hw_q <= bus.hw_int;
         if (wr_cause) ip_sw_q <= bus.c0_wdata[9:8];
         if (take_exc) begin
            exc_code_q <= take_sync ? bus.exc_code_i : 5'd0;
            redirect_q <= HANDLER_ADDR;
            if (!exl_q) begin
               bd_q  <= bus.in_delay_slot;
               epc_q <= bus.in_delay_slot ? bus.pc_i - 32'd4 : bus.pc_i;
            end
         end else if (take_eret) begin
            redirect_q <= epc_q;
         end else if (wr_epc) begin
            epc_q <= bus.c0_wdata;
         end
      end
   end

   // mfc0 read mux
   always_comb begin
      rdata = '0;
      case (bus.c0_raddr)
         REG_COUNT:   rdata = count_q;
         REG_COMPARE: rdata = compare_q;
         REG_STATUS:  rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
         REG_CAUSE:   rdata = {bd_q, ti_q, 14'b0, cause_ip, 1'b0, exc_code_q, 2'b0};
         REG_EPC:     rdata = epc_q;
         default:     rdata = '0;
      endcase
   end

   assign bus.c0_rdata = rdata;
endmodule

// File: tb/tb_c0_exc_ctrl.sv
// Bench for c0_exc_ctrl: directed scenarios then random traffic, all outputs
// compared every cycle against a behavioural CP0 model.
module tb_c0_exc_ctrl;
   localparam int          NHW     = 6;
   localparam logic [31:0] HANDLER = 32'h0000_0180;

   logic sys_clk = 1'b0;
   logic rst;

   c0_exc_ctrl_if #(.NUM_HW_INT(NHW)) bus ();

   c0_exc_ctrl #(.HANDLER_ADDR(HANDLER), .NUM_HW_INT(NHW)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Count is modelled as load value plus half the cycles elapsed since load.
   logic [31:0]     m_base, m_cmp, m_epc, m_redir;
   int unsigned     m_age;
   logic [7:0]      m_im;
   logic            m_exl, m_ie, m_bd, m_ti, m_flush;
   logic [1:0]      m_ipsw;
   logic [NHW-1:0]  m_hw;
   logic [4:0]      m_code;

   function automatic logic [31:0] m_count();
      return m_base + 32'(m_age / 2);
   endfunction

   function automatic logic [7:0] m_ip();
      logic [7:0] ip;
      ip    = {m_hw, m_ipsw};
      ip[7] = ip[7] | m_ti;
      return ip;
   endfunction

   function automatic logic m_pend();
      return (|(m_ip() & m_im)) && m_ie && !m_exl;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      case (r)
         5'd9:    return m_count();
         5'd11:   return m_cmp;
         5'd12:   return {16'b0, m_im, 6'b0, m_exl, m_ie};
         5'd13:   return {m_bd, m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b0};
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_base = '0; m_age = 0; m_cmp = '0; m_epc = '0; m_redir = '0;
      m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_flush = 0;
      m_ipsw = '0; m_hw = '0; m_code = '0;
   endtask

   // Advance model by one clock using the inputs currently driven
   task automatic m_step();
      logic [31:0] old_cnt, new_cnt, cmp_now;
      logic        exc, ret, wc, wcmp;
      if (rst) begin
         m_reset();
         return;
      end
      exc = 0; ret = 0;
      if (!m_flush && bus.pc_valid) begin
         if (bus.sync_exc || m_pend()) exc = 1;
         else if (bus.eret)            ret = 1;
      end
      old_cnt = m_count();
      cmp_now = m_cmp;
      wc   = bus.c0_we && bus.c0_waddr == 5'd9;
      wcmp = bus.c0_we && bus.c0_waddr == 5'd11;
      if (wc) begin m_base = bus.c0_wdata; m_age = 0; end
      else m_age++;
      new_cnt = m_count();
      if (wcmp) begin
         m_ti  = 0;
         m_cmp = bus.c0_wdata;
      end else if ((wc || new_cnt != old_cnt) && new_cnt == cmp_now) begin
         m_ti = 1;
      end
      if (exc) begin
         m_code  = bus.sync_exc ? bus.exc_code_i : 5'd0;
         m_redir = HANDLER;
         if (!m_exl) begin
            m_bd  = bus.in_delay_slot;
            m_epc = bus.in_delay_slot ? bus.pc_i - 32'd4 : bus.pc_i;
         end
         m_exl = 1;
      end else if (ret) begin
         m_redir = m_epc;
         m_exl   = 0;
      end else if (bus.c0_we) begin
         case (bus.c0_waddr)
            5'd12: begin m_im = bus.c0_wdata[15:8]; m_exl = bus.c0_wdata[1]; m_ie = bus.c0_wdata[0]; end
            5'd13: m_ipsw = bus.c0_wdata[9:8];
            5'd14: m_epc  = bus.c0_wdata;
            default: ;
         endcase
      end
      m_hw    = bus.hw_int;
      m_flush = exc || ret;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      rst = 0;
      bus.pc_valid = 0; bus.pc_i = '0; bus.in_delay_slot = 0;
      bus.sync_exc = 0; bus.exc_code_i = '0; bus.eret = 0;
      bus.c0_we = 0; bus.c0_waddr = '0; bus.c0_wdata = '0; bus.c0_raddr = '0;
   endtask

   // Compare all outputs with the model, then clock once
   task automatic cycle();
      #1;
      chk("flush", 32'(bus.flush), 32'(m_flush));
      if (m_flush) chk("redirect_pc", bus.redirect_pc, m_redir);
      chk($sformatf("rdata[%0d]", bus.c0_raddr), bus.c0_rdata, m_read(bus.c0_raddr));
      chk("int_pending", 32'(bus.int_pending), 32'(m_pend()));
      m_step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic peek(input string tag, input logic [4:0] r, input logic [31:0] exp);
      bus.c0_raddr = r;
      #1;
      chk(tag, bus.c0_rdata, exp);
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      idle();
      bus.c0_we = 1; bus.c0_waddr = r; bus.c0_wdata = d;
      cycle();
   endtask

   task automatic commit(input logic s, input logic [4:0] code, input logic e,
                         input logic ds, input logic [31:0] pc);
      idle();
      bus.pc_valid = 1; bus.sync_exc = s; bus.exc_code_i = code; bus.eret = e;
      bus.in_delay_slot = ds; bus.pc_i = pc;
   endtask

   task automatic drive_rand();
      idle();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) bus.hw_int = NHW'($urandom);
      bus.pc_valid      = 1'($urandom_range(0, 1));
      bus.pc_i          = $urandom & 32'hFFFF_FFFC;
      bus.in_delay_slot = 1'($urandom_range(0, 1));
      bus.sync_exc      = ($urandom_range(0, 7) == 0);
      bus.exc_code_i    = 5'($urandom);
      bus.eret          = ($urandom_range(0, 4) == 0);
      bus.c0_we         = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 6))
         0: bus.c0_waddr = 5'd9;
         1: bus.c0_waddr = 5'd11;
         2: bus.c0_waddr = 5'd13;
         3: bus.c0_waddr = 5'd14;
         4: bus.c0_waddr = 5'($urandom);
         default: bus.c0_waddr = 5'd12;
      endcase
      bus.c0_wdata = $urandom;
      if (bus.c0_waddr == 5'd11) bus.c0_wdata = m_count() + 32'($urandom_range(0, 6));
      if (bus.c0_waddr == 5'd9 && $urandom_range(0, 1) == 1)
         bus.c0_wdata = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
      if (bus.c0_waddr == 5'd12 && $urandom_range(0, 2) != 0) begin
         bus.c0_wdata[0] = 1'b1;
         bus.c0_wdata[1] = 1'b0;
      end
      case ($urandom_range(0, 5))
         0: bus.c0_raddr = 5'd9;
         1: bus.c0_raddr = 5'd11;
         2: bus.c0_raddr = 5'd12;
         3: bus.c0_raddr = 5'd13;
         4: bus.c0_raddr = 5'd14;
         default: bus.c0_raddr = 5'($urandom);
      endcase
   endtask

   initial begin
      logic [4:0] regs [5];
      regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
      idle();
      bus.hw_int = '0;
      rst = 1;
      m_reset();
      @(posedge sys_clk);
      #1;

      // reset state and Count pacing
      rst = 1; cycle();
      for (int i = 0; i < 10; i++) begin
         idle();
         bus.c0_raddr = regs[i % 5];
         cycle();
      end
      peek("count_after_10", 5'd9, 32'd5);

      // hardware interrupt entry
      mtc0(5'd12, 32'h0000_0401);
      idle(); bus.hw_int = 6'b000001; cycle();
      commit(0, 5'd0, 0, 0, 32'h0040_0010); cycle();
      chk("irq_flush", 32'(bus.flush), 32'd1);
      chk("irq_redirect", bus.redirect_pc, HANDLER);
      idle(); cycle();
      chk("irq_flush_drop", 32'(bus.flush), 32'd0);
      peek("irq_epc", 5'd14, 32'h0040_0010);
      peek("irq_status", 5'd12, 32'h0000_0403);
      peek("irq_cause", 5'd13, 32'h0000_0400);
      idle(); bus.hw_int = '0; cycle();
      commit(0, 5'd0, 1, 0, 32'h0040_0014); cycle();
      chk("eret1_redirect", bus.redirect_pc, 32'h0040_0010);
      idle(); cycle();

      // delay-slot sync exception then eret
      commit(1, 5'd8, 0, 1, 32'h0040_0024); cycle();
      idle(); cycle();
      peek("ds_epc", 5'd14, 32'h0040_0020);
      peek("ds_cause", 5'd13, 32'h8000_0020);
      commit(0, 5'd0, 1, 0, 32'h0040_0030); cycle();
      chk("eret2_flush", 32'(bus.flush), 32'd1);
      chk("eret2_redirect", bus.redirect_pc, 32'h0040_0020);
      idle(); cycle();
      peek("eret2_status", 5'd12, 32'h0000_0401);

      // sync + interrupt + eret + mtc0 Status all in one cycle
      idle(); bus.hw_int = 6'b000001; cycle();
      commit(1, 5'd4, 1, 0, 32'h0040_0100);
      bus.c0_we = 1; bus.c0_waddr = 5'd12; bus.c0_wdata = 32'd0;
      cycle();
      chk("prio_redirect", bus.redirect_pc, HANDLER);
      idle(); cycle();
      peek("prio_status", 5'd12, 32'h0000_0403);
      peek("prio_cause", 5'd13, 32'h0000_0410);
      peek("prio_epc", 5'd14, 32'h0040_0100);
      idle(); bus.hw_int = '0; cycle();
      mtc0(5'd12, 32'h0000_0401);

      // timer match and clear
      mtc0(5'd11, 32'd3);
      mtc0(5'd9, 32'd0);
      for (int i = 0; i < 6; i++) begin
         idle(); bus.c0_raddr = 5'd13; cycle();
      end
      peek("ti_set", 5'd13, 32'h4000_8010);
      mtc0(5'd11, 32'd100);
      peek("ti_clear", 5'd13, 32'h0000_0010);

      // reset during TRAP
      commit(1, 5'd10, 0, 0, 32'h0040_0200); cycle();
      idle(); rst = 1; cycle();
      chk("rst_trap_flush", 32'(bus.flush), 32'd0);
      peek("rst_trap_status", 5'd12, 32'd0);
      peek("rst_trap_epc", 5'd14, 32'd0);
      peek("rst_trap_cause", 5'd13, 32'd0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         drive_rand();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
